// File: rtl/segment_writer_if.sv
// Avalon-MM bus bundle between segment_writer (master) and the display register slave.
interface segment_writer_if;
  // Handshake: a raised write or read strobe, together with address and data,
  // is a request. It is accepted on the first rising clock edge where
  // waitrequest is low. Until then the master keeps the strobe and data steady.
  logic [3:0]  address;
  logic        write;
  logic        read;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic [63:0] readdata;
  logic        waitrequest;

  modport master (
    output address, write, read, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/segment_writer.sv
// Encodes 8 hex digits + decimal points to active-low 7-segment bytes and writes them as one 64-bit word.
// Optional readback check is compiled in with `define SEGMENT_WRITER_VERIFY_EN.
module segment_writer #(
  parameter logic [3:0] SEG_ADDR     = 4'h0,
  parameter int         READ_LATENCY = 3,
  parameter bit         AUTO_REFRESH = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic        update,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  fsm_state,
  segment_writer_if.master avm
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ENC   = 3'd1;
  localparam logic [2:0] WR    = 3'd2;
`ifdef SEGMENT_WRITER_VERIFY_EN
  localparam logic [2:0] RD    = 3'd3;
  localparam logic [2:0] RWAIT = 3'd4;
  localparam logic [2:0] CMP   = 3'd5;
`endif

  logic [2:0]  state;
  logic        pending;
  logic [63:0] wdata;
  logic [31:0] last_digits;
  logic [7:0]  last_dp;
  logic        inputs_changed;
  logic        start;

  // Segment order in a byte: bit7=dp, bits6..0 = g..a, all active-low.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib, input logic dp);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'hFF;
    endcase
    s[7] = s[7] & ~dp;
    return s;
  endfunction

  function automatic logic [63:0] encode_word(input logic [31:0] d, input logic [7:0] p);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[8*i +: 8] = seg_encode(d[4*i +: 4], p[i]);
    end
    return w;
  endfunction

  assign inputs_changed = (digits_in != last_digits) || (dp_in != last_dp);
  assign start          = update || pending || (AUTO_REFRESH && inputs_changed);

  assign busy           = (state != IDLE);
  assign fsm_state      = state;
  assign avm.address    = SEG_ADDR;
  assign avm.byteenable = 8'hFF;
  assign avm.writedata  = wdata;
  assign avm.write      = (state == WR);

`ifdef SEGMENT_WRITER_VERIFY_EN
  logic [2:0]  lat_cnt;
  logic [63:0] rd_cap;
  logic        err_q;

  assign avm.read = (state == RD);
  assign error    = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
      rd_cap  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == RD && !avm.waitrequest) begin
        lat_cnt <= '0;
      end else if (state == RWAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
        if (lat_cnt == 3'(READ_LATENCY - 1)) begin
          rd_cap <= avm.readdata;
        end
      end
      // error stays set until reset, even across later good readbacks
      if (state == CMP && rd_cap != wdata) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{avm.readdata, 3'(READ_LATENCY)};
  assign avm.read  = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      done        <= 1'b0;
      wdata       <= '0;
      last_digits <= '0;
      last_dp     <= '0;
    end else begin
      done <= 1'b0;
      // Requests arriving while a transaction is in flight collapse into one.
      if (update && state != IDLE) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ENC;
            pending <= 1'b0;
          end
        end
        ENC: begin
          wdata       <= encode_word(digits_in, dp_in);
          last_digits <= digits_in;
          last_dp     <= dp_in;
          state       <= WR;
        end
        WR: begin
          if (!avm.waitrequest) begin
`ifdef SEGMENT_WRITER_VERIFY_EN
            state <= RD;
`else
            state <= IDLE;
            done  <= 1'b1;
`endif
          end
        end
`ifdef SEGMENT_WRITER_VERIFY_EN
        RD: begin
          if (!avm.waitrequest) begin
            state <= RWAIT;
          end
        end
        RWAIT: begin
          if (lat_cnt == 3'(READ_LATENCY - 1)) begin
            state <= CMP;
          end
        end
        CMP: begin
          done  <= 1'b1;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_writer.sv
// Directed bench for segment_writer: one default instance plus one AUTO_REFRESH=1 instance.
module tb_segment_writer;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ENC  = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;

  logic        clk;
  logic        reset;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic        update;
  logic        busy, done, error;
  logic [2:0]  fsm_state;

  logic [31:0] a_digits;
  logic [7:0]  a_dp;
  logic        a_update;
  logic        a_busy, a_done, a_error;
  logic [2:0]  a_state;

  segment_writer_if bus ();
  segment_writer_if a_bus ();

  segment_writer #(.SEG_ADDR(4'h0), .READ_LATENCY(3), .AUTO_REFRESH(1'b0)) dut (
    .clk(clk), .reset(reset), .digits_in(digits), .dp_in(dp), .update(update),
    .busy(busy), .done(done), .error(error), .fsm_state(fsm_state), .avm(bus)
  );

  segment_writer #(.SEG_ADDR(4'h0), .READ_LATENCY(3), .AUTO_REFRESH(1'b1)) dut_auto (
    .clk(clk), .reset(reset), .digits_in(a_digits), .dp_in(a_dp), .update(a_update),
    .busy(a_busy), .done(a_done), .error(a_error), .fsm_state(a_state), .avm(a_bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- slave models and monitors ----------------
  logic [63:0] slave_mem = '0;
  logic [63:0] corrupt   = '0;
  int          wr_count  = 0;
  int          a_wr_count = 0;
  logic [63:0] a_last    = '0;
  logic        rd_seen = 1'b0, both_seen = 1'b0, drop_seen = 1'b0;
  logic        prev_w = 1'b0, prev_wait = 1'b0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  assign bus.readdata      = slave_mem ^ corrupt;
  assign a_bus.readdata    = '0;
  assign a_bus.waitrequest = 1'b0;

  always @(posedge clk) begin
    if (reset && bus.write && !bus.waitrequest) begin
      wr_count  <= wr_count + 1;
      slave_mem <= bus.writedata;
      obs_q.push_back(bus.writedata);
    end
    if (reset && bus.read) rd_seen <= 1'b1;
    if ((bus.write && bus.read) || (a_bus.write && a_bus.read)) both_seen <= 1'b1;
    if (reset && prev_w && prev_wait && !bus.write) drop_seen <= 1'b1;
    prev_w    <= reset & bus.write;
    prev_wait <= bus.waitrequest;
    if (reset && a_bus.write && !a_bus.waitrequest) begin
      a_wr_count <= a_wr_count + 1;
      a_last     <= a_bus.writedata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; #2; reset = 1'b0;
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_tests++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", bus.write); end
    n_tests++; if (bus.read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", bus.read); end
    n_tests++; if (bus.writedata !== 64'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.writedata); end
    n_tests++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    n_tests++; if (bus.address !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.address); end
    n_tests++; if (bus.byteenable !== 8'hFF) begin n_fail++; $display("FAIL reset_be: got %h want ff", bus.byteenable); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int base;
    base = wr_count;
    bus.waitrequest = 1'b0;
    digits = 32'h12345678; dp = 8'h00;
    exp_q.push_back(64'hF9A4B0999282F880);
    pulse_update();
    n_tests++; if (fsm_state !== ST_ENC) begin n_fail++; $display("FAIL basic_enc: got %0d want %0d", fsm_state, ST_ENC); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    n_tests++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_write: got %b want 0", bus.write); end
    tick();
    n_tests++; if (bus.write !== 1'b1) begin n_fail++; $display("FAIL basic_write_n2: got %b want 1", bus.write); end
    n_tests++; if (bus.writedata !== 64'hF9A4B0999282F880) begin n_fail++; $display("FAIL basic_wdata: got %h want f9a4b0999282f880", bus.writedata); end
    tick();
`ifndef SEGMENT_WRITER_VERIFY_EN
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done_n3: got %b want 1", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_n3: got %b want 0", busy); end
    n_tests++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL basic_write_drop: got %b want 0", bus.write); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
`else
    wait_done(40, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done_timeout: got %b want 1", ok); end
    tick();
`endif
    n_tests++; if (wr_count !== base + 1) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", wr_count, base + 1); end
  endtask

  task automatic test_blank_dp_stall();
    bit ok;
    int hi;
    bit stable;
    logic [63:0] first;
    bus.waitrequest = 1'b1;
    digits = 32'hFFFFFFF0; dp = 8'h02;
    exp_q.push_back(64'hFFFFFFFFFFFF7FC0);
    pulse_update();
    tick();
    hi = 0; stable = 1'b1; first = bus.writedata;
    for (int i = 0; i < 20 && bus.write; i++) begin
      hi++;
      if (bus.writedata !== first) stable = 1'b0;
      if (hi == 6) bus.waitrequest = 1'b0;
      tick();
    end
    bus.waitrequest = 1'b0;
    n_tests++; if (first !== 64'hFFFFFFFFFFFF7FC0) begin n_fail++; $display("FAIL blank_dp_wdata: got %h want ffffffffffff7fc0", first); end
    n_tests++; if (hi !== 6) begin n_fail++; $display("FAIL stall_write_cycles: got %0d want 6", hi); end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL stall_wdata_stable: got %b want 1", stable); end
    wait_done(40, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_done_timeout: got %b want 1", ok); end
    tick();
  endtask

  task automatic test_coalesce();
    bit ok;
    int base;
    base = wr_count;
    bus.waitrequest = 1'b1;
    digits = 32'h01234567; dp = 8'h00;
    exp_q.push_back(64'hC0F9A4B0999282F8);
    exp_q.push_back(64'h00908883C6A1867F);
    pulse_update();
    tick();
    pulse_update();
    pulse_update();
    digits = 32'h89ABCDEF; dp = 8'h81;
    bus.waitrequest = 1'b0;
    wait_done(40, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coalesce_first_done: got %b want 1", ok); end
    tick();
    wait_done(40, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coalesce_second_done: got %b want 1", ok); end
    repeat (10) tick();
    n_tests++; if (wr_count !== base + 2) begin n_fail++; $display("FAIL coalesce_count: got %0d want %0d", wr_count - base, 2); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coalesce_idle: got %b want 0", busy); end
  endtask

  task automatic test_update_on_done();
    bit ok;
    int base;
    base = wr_count;
    bus.waitrequest = 1'b0;
    digits = 32'h00000000; dp = 8'h00;
    exp_q.push_back(64'hC0C0C0C0C0C0C0C0);
    exp_q.push_back(64'hF9F9F9F9F9F9F9F9);
    pulse_update();
    wait_done(40, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL done_upd_first: got %b want 1", ok); end
    digits = 32'h11111111;
    update = 1'b1;
    tick();
    update = 1'b0;
    wait_done(40, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL done_upd_second: got %b want 1", ok); end
    repeat (5) tick();
    n_tests++; if (wr_count !== base + 2) begin n_fail++; $display("FAIL done_upd_count: got %0d want %0d", wr_count - base, 2); end
  endtask

  task automatic test_reset_mid_write();
    int base;
    base = wr_count;
    bus.waitrequest = 1'b1;
    digits = 32'h00000009; dp = 8'h00;
    pulse_update();
    tick();
    n_tests++; if (fsm_state !== ST_WR) begin n_fail++; $display("FAIL rst_mid_in_wr: got %0d want %0d", fsm_state, ST_WR); end
    #1 reset = 1'b0;
    #1;
    n_tests++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL rst_mid_write: got %b want 0", bus.write); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_tests++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d want 0", fsm_state); end
    @(negedge clk);
    reset = 1'b1;
    bus.waitrequest = 1'b0;
    repeat (6) tick();
    n_tests++; if (wr_count !== base) begin n_fail++; $display("FAIL rst_mid_no_replay: got %0d want %0d", wr_count, base); end
    n_tests++; if (bus.writedata !== 64'h0) begin n_fail++; $display("FAIL rst_mid_wdata: got %h want 0", bus.writedata); end
  endtask

  task automatic test_no_auto();
    int base;
    base = wr_count;
    digits = 32'h55555555; dp = 8'h10;
    repeat (10) tick();
    n_tests++; if (wr_count !== base) begin n_fail++; $display("FAIL no_auto_count: got %0d want %0d", wr_count, base); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL no_auto_busy: got %b want 0", busy); end
  endtask

  task automatic test_error_path();
`ifdef SEGMENT_WRITER_VERIFY_EN
    bit ok;
    corrupt = 64'h0;
    digits = 32'h00000003; dp = 8'h00;
    exp_q.push_back(64'hC0C0C0C0C0C0C0B0);
    pulse_update();
    wait_done(60, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL verify_good_done: got %b want 1", ok); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL verify_good_error: got %b want 0", error); end
    tick();
    corrupt = 64'h0000000000000100;
    exp_q.push_back(64'hC0C0C0C0C0C0C0B0);
    pulse_update();
    wait_done(60, ok);
    tick();
    n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL verify_bad_error: got %b want 1", error); end
    corrupt = 64'h0;
    exp_q.push_back(64'hC0C0C0C0C0C0C0B0);
    pulse_update();
    wait_done(60, ok);
    tick();
    n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL verify_sticky: got %b want 1", error); end
`else
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL error_tied: got %b want 0", error); end
    n_tests++; if (rd_seen !== 1'b0) begin n_fail++; $display("FAIL read_tied: got %b want 0", rd_seen); end
`endif
  endtask

  task automatic test_auto_refresh();
    n_tests++; if (a_wr_count !== 0) begin n_fail++; $display("FAIL auto_quiet: got %0d want 0", a_wr_count); end
    a_digits = 32'h00000042;
    repeat (10) tick();
    n_tests++; if (a_wr_count !== 1) begin n_fail++; $display("FAIL auto_one_write: got %0d want 1", a_wr_count); end
    n_tests++; if (a_last !== 64'hC0C0C0C0C0C099A4) begin n_fail++; $display("FAIL auto_wdata: got %h want c0c0c0c0c0c099a4", a_last); end
    repeat (20) tick();
    n_tests++; if (a_wr_count !== 1) begin n_fail++; $display("FAIL auto_steady: got %0d want 1", a_wr_count); end
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL auto_idle: got %b want 0", a_busy); end
  endtask

  task automatic test_protocol();
    n_tests++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL proto_rw_overlap: got %b want 0", both_seen); end
    n_tests++; if (drop_seen !== 1'b0) begin n_fail++; $display("FAIL proto_strobe_drop: got %b want 0", drop_seen); end
  endtask

  task automatic test_scoreboard();
    logic [63:0] e, o;
    n_tests++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL sb_size: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL sb_write: got %h want %h", o, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    digits = '0; dp = '0; update = 1'b0;
    a_digits = '0; a_dp = '0; a_update = 1'b0;
    bus.waitrequest = 1'b0;
    test_reset();
    test_basic();
    test_blank_dp_stall();
    test_coalesce();
    test_update_on_done();
    test_reset_mid_write();
    test_no_auto();
    test_error_path();
    test_auto_refresh();
    test_protocol();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
